// File: rtl/goertzel_bin_detector.sv
// Groups paired Goertzel magnitudes into frames of 2*NUM_PAIRS bins and
// publishes, once per frame, a debounced hysteretic tone-present mask plus
// the strongest bin and its magnitude.
//
// Per-bin debounce state
//   state | meaning
//   0     | tone absent; counting frames with mag >= THRESH_ON
//   1     | tone present; counting frames with mag <  THRESH_OFF
module goertzel_bin_detector #(
  parameter int               NUM_PAIRS  = 5,
  parameter int               MAG_W      = 16,
  parameter logic [MAG_W-1:0] THRESH_ON  = 'h0800,
  parameter logic [MAG_W-1:0] THRESH_OFF = 'h0600,
  parameter int               DEBOUNCE   = 3
) (
  input  logic                            sys_clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [MAG_W-1:0]                mag_0,
  input  logic [MAG_W-1:0]                mag_1,
  input  logic                            mag_valid,
  output logic [2*NUM_PAIRS-1:0]          bin_active,
  output logic [$clog2(2*NUM_PAIRS)-1:0]  peak_bin,
  output logic [MAG_W-1:0]                peak_mag,
  output logic                            frame_done
);

  localparam int NB = 2 * NUM_PAIRS;
  localparam int BW = $clog2(NB);
  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [PW-1:0]           pair_idx;
  logic [MAG_W-1:0]        run_max;
  logic [BW-1:0]           run_idx;
  logic [NB-1:0]           bin_state;
  logic [NB-1:0][CW-1:0]   cnt;

  logic                    accept;
  logic                    last_pair;
  logic [MAG_W-1:0]        pair_mag;
  logic [BW-1:0]           pair_bin;
  logic [MAG_W-1:0]        max_nxt;
  logic [BW-1:0]           idx_nxt;
  logic [NB-1:0]           state_nxt;
  logic [NB-1:0][CW-1:0]   cnt_nxt;
  logic [MAG_W-1:0]        sample;
  logic                    qualify;

  // Running maximum: pick the pair winner (odd bin only if strictly larger),
  // then merge with the frame max; the first pair of a frame loads outright.
  always_comb begin
    accept    = enable & mag_valid;
    last_pair = accept && (pair_idx == PW'(NUM_PAIRS - 1));
    if (mag_1 > mag_0) begin
      pair_mag = mag_1;
      pair_bin = (BW'(pair_idx) << 1) | BW'(1);
    end else begin
      pair_mag = mag_0;
      pair_bin = BW'(pair_idx) << 1;
    end
    max_nxt = run_max;
    idx_nxt = run_idx;
    if ((pair_idx == '0) || (pair_mag > run_max)) begin
      max_nxt = pair_mag;
      idx_nxt = pair_bin;
    end
  end

  // Debounce update for the two bins addressed by the accepted pair.
  always_comb begin
    state_nxt = bin_state;
    cnt_nxt   = cnt;
    sample    = '0;
    qualify   = 1'b0;
    for (int k = 0; k < NB; k++) begin
      sample  = ((k % 2) == 1) ? mag_1 : mag_0;
      qualify = bin_state[k] ? (sample < THRESH_OFF) : (sample >= THRESH_ON);
      if (accept && (PW'(k / 2) == pair_idx)) begin
        if (qualify) begin
          if (cnt[k] == CW'(DEBOUNCE - 1)) begin
            state_nxt[k] = ~bin_state[k];
            cnt_nxt[k]   = '0;
          end else begin
            cnt_nxt[k] = cnt[k] + CW'(1);
          end
        end else begin
          cnt_nxt[k] = '0;
        end
      end
    end
  end

  // Frame sequencing, debounce state and frame-coherent output registers.
  // Outputs load on the same edge that accepts the final pair, so they
  // already include that pair's contribution.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_idx   <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      bin_state  <= '0;
      cnt        <= '0;
      bin_active <= '0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      bin_state  <= state_nxt;
      cnt        <= cnt_nxt;
      if (!enable) begin
        pair_idx <= '0;
        run_max  <= '0;
        run_idx  <= '0;
      end else if (mag_valid) begin
        run_max <= max_nxt;
        run_idx <= idx_nxt;
        if (last_pair) begin
          pair_idx   <= '0;
          frame_done <= 1'b1;
          bin_active <= state_nxt;
          peak_bin   <= idx_nxt;
          peak_mag   <= max_nxt;
        end else begin
          pair_idx <= pair_idx + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_goertzel_bin_detector.sv
// Directed and randomized checks of goertzel_bin_detector against a
// frame-level reference model: samples are collected into a frame list,
// each sample's position in the list is its bin, and the peak is a plain
// argmax over the finished list.
module tb_goertzel_bin_detector;

  localparam int NP       = 5;
  localparam int NB       = 2 * NP;
  localparam int DEBOUNCE = 3;
  localparam logic [15:0] TON  = 16'h0800;
  localparam logic [15:0] TOFF = 16'h0600;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] mag_0;
  logic [15:0] mag_1;
  logic        mag_valid;
  logic [NB-1:0] bin_active;
  logic [3:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        frame_done;

  goertzel_bin_detector dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mag_0      (mag_0),
    .mag_1      (mag_1),
    .mag_valid  (mag_valid),
    .bin_active (bin_active),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state
  int          st  [NB];
  int          cnt [NB];
  logic [15:0] fq  [$];
  logic        exp_fd;
  logic [NB-1:0] exp_active;
  logic [3:0]  exp_pbin;
  logic [15:0] exp_pmag;

  logic [15:0] fr    [NB];
  int          cls   [NB];
  logic [15:0] edges [4] = '{16'h05FF, 16'h0600, 16'h07FF, 16'h0800};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      st[k]  = 0;
      cnt[k] = 0;
    end
    fq.delete();
    exp_fd     = 1'b0;
    exp_active = '0;
    exp_pbin   = '0;
    exp_pmag   = '0;
  endtask

  task automatic model_sample(input int k, input logic [15:0] m);
    bit qual;
    qual = (st[k] != 0) ? (m < TOFF) : (m >= TON);
    if (qual) begin
      cnt[k]++;
      if (cnt[k] == DEBOUNCE) begin
        st[k]  = 1 - st[k];
        cnt[k] = 0;
      end
    end else begin
      cnt[k] = 0;
    end
  endtask

  // One clock cycle: apply inputs, advance the model, then compare every
  // output at the following falling edge.
  task automatic tick(input bit en, input bit mv, input logic [15:0] m0, input logic [15:0] m1);
    enable    = en;
    mag_valid = mv;
    mag_0     = m0;
    mag_1     = m1;
    exp_fd    = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else if (!en) begin
      fq.delete();
    end else if (mv) begin
      fq.push_back(m0);
      model_sample(fq.size() - 1, m0);
      fq.push_back(m1);
      model_sample(fq.size() - 1, m1);
      if (fq.size() == NB) begin
        exp_fd = 1'b1;
        for (int k = 0; k < NB; k++) exp_active[k] = (st[k] != 0);
        exp_pbin = 4'd0;
        exp_pmag = fq[0];
        for (int k = 1; k < NB; k++) begin
          if (fq[k] > exp_pmag) begin
            exp_pmag = fq[k];
            exp_pbin = 4'(k);
          end
        end
        fq.delete();
      end
    end
    @(negedge sys_clk);
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("bin_active", 32'(bin_active), 32'(exp_active));
    check("peak_bin",   32'(peak_bin),   32'(exp_pbin));
    check("peak_mag",   32'(peak_mag),   32'(exp_pmag));
  endtask

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < NB; k++) fr[k] = v;
  endtask

  task automatic send_frame(input int gap);
    for (int p = 0; p < NP; p++) begin
      tick(1'b1, 1'b1, fr[2*p], fr[2*p+1]);
      for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic reset_pulse(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_active",   32'(bin_active), 32'h0);
    check("rst_async_peak_bin", 32'(peak_bin),   32'h0);
    check("rst_async_peak_mag", 32'(peak_mag),   32'h0);
    check("rst_async_fd",       32'(frame_done), 32'h0);
    model_clear();
    for (int i = 0; i < cycles; i++) tick(1'b1, bit'(i % 2 == 0), 16'hFFFF, 16'hFFFF);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] mag_of(input int c);
    logic [15:0] v;
    case (c)
      0:       v = 16'($urandom_range(0, 32'h05FF));
      1:       v = 16'($urandom_range(32'h0600, 32'h07FF));
      2:       v = 16'($urandom_range(32'h0800, 32'hFFFF));
      default: v = edges[$urandom_range(0, 3)];
    endcase
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    mag_valid = 1'b0;
    mag_0     = '0;
    mag_1     = '0;
    model_clear();

    // reset held with mag_valid toggling
    for (int i = 0; i < 4; i++) tick(1'b1, bit'(i % 2), 16'hFFFF, 16'hFFFF);
    rst_n = 1'b1;

    // bin 3 asserts only on the third qualifying frame
    for (int f = 0; f < 3; f++) begin
      fill(16'h0100);
      fr[3] = 16'h0900;
      send_frame(1);
      check("t2_peak_bin", 32'(peak_bin), 32'd3);
      check("t2_peak_mag", 32'(peak_mag), 32'h0900);
      check("t2_active",   32'(bin_active), (f == 2) ? 32'h008 : 32'h000);
    end

    // hysteresis band holds, below THRESH_OFF clears after DEBOUNCE frames
    for (int f = 0; f < 5; f++) begin
      fill(16'h0100);
      fr[3] = 16'h0700;
      send_frame(0);
      check("t3_band_hold", 32'(bin_active[3]), 32'd1);
    end
    for (int f = 0; f < 3; f++) begin
      fill(16'h0100);
      fr[3] = 16'h0500;
      send_frame(0);
      check("t3_clear", 32'(bin_active[3]), (f == 2) ? 32'd0 : 32'd1);
    end
    for (int f = 0; f < 3; f++) begin
      fill(16'h0100);
      fr[3] = 16'h0900;
      send_frame(2);
    end
    check("t3_reassert", 32'(bin_active[3]), 32'd1);
    begin
      logic [15:0] seq [4];
      seq = '{16'h0500, 16'h0500, 16'h0700, 16'h0500};
      for (int f = 0; f < 4; f++) begin
        fill(16'h0100);
        fr[3] = seq[f];
        send_frame(0);
        check("t3_interrupted", 32'(bin_active[3]), 32'd1);
      end
    end

    // ties resolve to the lower bin
    fill(16'h0100);
    fr[4] = 16'h0A00;
    fr[5] = 16'h0A00;
    send_frame(1);
    check("t4_pair_tie_bin", 32'(peak_bin), 32'd4);
    check("t4_pair_tie_mag", 32'(peak_mag), 32'h0A00);
    fill(16'h0100);
    fr[2] = 16'h0B00;
    fr[6] = 16'h0B00;
    send_frame(0);
    check("t4_cross_tie_bin", 32'(peak_bin), 32'd2);

    // resync discards the partial frame
    for (int p = 0; p < 3; p++) tick(1'b1, 1'b1, 16'hF000, 16'hF000);
    tick(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    tick(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    fill(16'h0100);
    fr[9] = 16'h0C00;
    send_frame(1);
    check("t5_peak_bin", 32'(peak_bin), 32'd9);
    check("t5_peak_mag", 32'(peak_mag), 32'h0C00);

    // back-to-back frames, then reset mid-frame
    for (int k = 0; k < NB; k++) fr[k] = 16'(16'h0200 + 16'(k) * 16'h0010);
    send_frame(0);
    fr[0] = 16'h0F00;
    send_frame(0);
    check("t6_b2b_peak_bin", 32'(peak_bin), 32'd0);
    tick(1'b1, 1'b1, 16'h0900, 16'h0900);
    tick(1'b1, 1'b1, 16'h0900, 16'h0900);
    reset_pulse(2);
    for (int f = 0; f < 3; f++) begin
      fill(16'h0100);
      fr[7] = 16'h0900;
      send_frame(0);
      check("t6_post_rst_active", 32'(bin_active), (f == 2) ? 32'h080 : 32'h000);
    end

    // randomized frames with gaps, resyncs, ties and one reset
    for (int k = 0; k < NB; k++) cls[k] = int'($urandom_range(0, 3));
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 3) == 0) cls[k] = int'($urandom_range(0, 3));
        fr[k] = mag_of(cls[k]);
      end
      if ($urandom_range(0, 5) == 0) fr[2*$urandom_range(0, NP-1)+1] = fr[0];
      for (int p = 0; p < NP; p++) begin
        tick(1'b1, 1'b1, fr[2*p], fr[2*p+1]);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          tick(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        if ($urandom_range(0, 24) == 0)
          tick(1'b0, bit'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      if (f == 20) reset_pulse(1);
    end

    tick(1'b1, 1'b0, 16'h0000, 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
